// File: rtl/pk_stream_reader.sv
// pk_stream_reader: streams a window of the step-line data memory to the host over valid/ready,
// hiding the one-cycle memory read latency behind a 2-entry output buffer.
module pk_stream_reader #(
  parameter int N = 4,
  parameter int M = 1,
  parameter int L = 8,
  parameter int K = 16,
  localparam int DEPTH = L * K / N,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int W = N * M
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] first_addr,
  input  logic [CW-1:0] num_words,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [W-1:0]  mem_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_data,
  output logic          m_last
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] rem_q, rem_d;
  logic infl_q, infl_d, infl_last_q, infl_last_d, done_q, done_d;
  logic [1:0] occ_q, occ_d, occ_pop, tag_q, tag_d;
  logic [1:0][W-1:0] buf_q, buf_d;
  logic pop, issue;
  logic [2:0] credit;
  always_comb begin
    pop = (occ_q != 2'd0) & m_ready;
    // a read may issue only if its data will find a free slot when it lands
    credit = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
    issue = (state_q == RUN) && (credit < 3'd2);
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    done_d = 1'b0;
    infl_d = issue;
    infl_last_d = issue && (rem_q == CW'(1));
    buf_d = buf_q;
    tag_d = tag_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
      tag_d[0] = tag_q[1];
    end
    occ_pop = occ_q - {1'b0, pop};
    if (infl_q) begin
      buf_d[occ_pop[0]] = mem_dout;
      tag_d[occ_pop[0]] = infl_last_q;
    end
    occ_d = occ_pop + {1'b0, infl_q};
    if (state_q == IDLE && start) begin
      if (num_words == '0) done_d = 1'b1;
      else begin
        state_d = RUN;
        addr_d = first_addr;
        rem_d = num_words;
      end
    end
    if (issue) begin
      addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
      rem_d = rem_q - CW'(1);
      state_d = (rem_q == CW'(1)) ? DRAIN : state_q;
    end
    if (pop && tag_q[0]) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      infl_q <= 1'b0;
      infl_last_q <= 1'b0;
      done_q <= 1'b0;
      occ_q <= '0;
      tag_q <= '0;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      infl_q <= infl_d;
      infl_last_q <= infl_last_d;
      done_q <= done_d;
      occ_q <= occ_d;
      tag_q <= tag_d;
      buf_q <= buf_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign mem_rd_en = issue;
  assign mem_rd_addr = addr_q;
  assign m_valid = occ_q != 2'd0;
  assign m_data = buf_q[0];
  assign m_last = m_valid & tag_q[0];
endmodule

// File: tb/tb_pk_stream_reader.sv
// tb_pk_stream_reader: randomized and directed jobs checked against a queue-based window model.
module tb_pk_stream_reader;
  localparam int N = 4, M = 1, L = 8, K = 16;
  localparam int DEPTH = L * K / N, AW = $clog2(DEPTH), CW = $clog2(DEPTH + 1), W = N * M;
  logic clk = 0, rst = 0, start = 0, m_ready = 1;
  logic [AW-1:0] first_addr = '0;
  logic [CW-1:0] num_words = '0;
  logic busy, done, mem_rd_en, m_valid, m_last;
  logic [AW-1:0] mem_rd_addr;
  logic [W-1:0] mem_dout = '0, m_data;
  logic [W-1:0] mem [DEPTH];
  int vectors = 0, miscompares = 0, cyc = 0, rmode = 0, pi = 0;
  int rd_cnt, pop_cnt, first_rd, last_rd, first_v, last_hs, done_cyc, done_cnt;
  bit busy_seen, prev_stall;
  logic [W:0] prev_word;
  logic [W:0] exp_q[$];
  int exp_addr[$];
  bit pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  pk_stream_reader #(.N(N), .M(M), .L(L), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .num_words(num_words),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_dout(mem_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_dout <= mem[mem_rd_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rmode == 0) m_ready = 1'b1;
    else if (rmode == 1) begin m_ready = pat[pi % 8]; pi++; end
    else m_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) if (rst) begin
    if (busy) busy_seen = 1;
    if (mem_rd_en) begin
      rd_cnt++;
      last_rd = cyc;
      if (first_rd < 0) first_rd = cyc;
      chk("rd_expected", exp_addr.size() != 0, 1);
      if (exp_addr.size() != 0) chk("rd_addr", 32'(mem_rd_addr), 32'(exp_addr.pop_front()));
    end
    if (m_valid && first_v < 0) first_v = cyc;
    if (prev_stall) chk("stall_stable", {m_valid, m_last, m_data}, {1'b1, prev_word});
    if (m_valid && m_ready) begin
      pop_cnt++;
      last_hs = cyc;
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("beat", {m_last, m_data}, exp_q.pop_front());
    end
    if (mem_rd_en) chk("outstanding_le2", (rd_cnt - pop_cnt) <= 2, 1);
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
      chk("busy_at_done", busy, 0);
    end
    prev_stall = m_valid && !m_ready;
    prev_word = {m_last, m_data};
  end

  task automatic setup_job(input int a, input int n, output int t0);
    @(posedge clk); #1;
    exp_q.delete();
    exp_addr.delete();
    rd_cnt = 0; pop_cnt = 0; first_rd = -1; last_rd = -1; first_v = -1;
    last_hs = -1; done_cyc = -1; done_cnt = 0; busy_seen = 0; prev_stall = 0;
    for (int j = 0; j < n; j++) begin
      exp_addr.push_back((a + j) % DEPTH);
      exp_q.push_back({j == n - 1, mem[(a + j) % DEPTH]});
    end
    start = 1; first_addr = AW'(a); num_words = CW'(n); t0 = cyc;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_job(input bit poke);
    for (int i = 0; i < 400 && done_cyc < 0; i++) begin
      @(posedge clk); #1;
      if (poke && i == 3) begin start = 1; first_addr = AW'(5); num_words = CW'(3); end
      if (poke && i == 4) start = 0;
    end
    chk("done_seen", done_cyc >= 0, 1);
    @(posedge clk); #1;
    chk("beats_left", exp_q.size(), 0);
    chk("reads_left", exp_addr.size(), 0);
    chk("done_count", done_cnt, 1);
  endtask

  initial begin
    int t0, a, n;
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int t0, a, n;
    for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
    #2;
    chk("rst_outs", {busy, done, mem_rd_en, m_valid, m_last}, 0);
    chk("rst_data", {mem_rd_addr, m_data}, 0);
    @(negedge clk); rst = 1;

    rmode = 0;
    setup_job(0, 32, t0);
    wait_job(0);
    chk("j1_first_rd", first_rd - t0, 1);
    chk("j1_last_rd", last_rd - t0, 32);
    chk("j1_rd_cnt", rd_cnt, 32);
    chk("j1_first_valid", first_v - t0, 3);
    chk("j1_last_hs", last_hs - t0, 34);
    chk("j1_done", done_cyc - t0, 35);

    setup_job(30, 4, t0);
    wait_job(0);
    chk("wrap_done", done_cyc - t0, 7);

    rmode = 1;
    setup_job(0, 8, t0);
    wait_job(1);
    chk("pat_pops", pop_cnt, 8);

    rmode = 0;
    setup_job(0, 0, t0);
    wait_job(0);
    chk("zero_done", done_cyc - t0, 1);
    chk("zero_busy", busy_seen, 0);
    chk("zero_rd", rd_cnt, 0);

    setup_job(0, 16, t0);
    repeat (4) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("abort_outs", {busy, done, mem_rd_en, m_valid, m_last}, 0);
    chk("abort_data", {mem_rd_addr, m_data}, 0);
    @(negedge clk); rst = 1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet", {done, busy, m_valid, mem_rd_en}, 0);
    end
    setup_job(10, 3, t0);
    wait_job(0);
    chk("fresh_pops", pop_cnt, 3);

    for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
    for (int r = 0; r < 25; r++) begin
      rmode = $urandom_range(0, 2);
      a = $urandom_range(0, DEPTH - 1);
      n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, DEPTH);
      setup_job(a, n, t0);
      wait_job(r % 4 == 1);
      chk("rand_pops", pop_cnt, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
